// File: rtl/vga_timing_controller.sv
// VGA raster timing: pixel-tick divider, column/row counters, syncs and markers.
// Run/stop control only ever halts the raster on a frame boundary.
module vga_timing_controller #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    output logic        pixel_tick,
    output logic [9:0]  currentColumn,
    output logic [9:0]  currentRow,
    output logic        video_on,
    output logic        hsync,
    output logic        vsync,
    output logic        line_start,
    output logic        frame_start,
    output logic [15:0] frame_count,
    output logic        busy
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = $clog2(CLK_DIV);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STOPPING
    } state_t;

    state_t           state;
    state_t           state_d;
    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] div_d;
    logic [9:0]       col_d;
    logic [9:0]       row_d;
    logic             tick;
    logic             h_wrap;
    logic             f_wrap;
    logic             line_d;
    logic             frame_d;
    logic [15:0]      count_d;
    logic             busy_d;
    logic             tick_d;
    logic             video_d;
    logic             hsync_d;
    logic             vsync_d;

    assign tick   = (state != IDLE) && (div == DIV_LAST);
    assign h_wrap = (currentColumn == H_LAST);
    assign f_wrap = h_wrap && (currentRow == V_LAST);

    // Next state: a stop request is honoured only by the final wrap of a frame.
    always_comb begin
        state_d = state;
        unique case (state)
            IDLE: begin
                if (enable) state_d = RUN;
            end
            RUN: begin
                if (!enable) state_d = STOPPING;
            end
            STOPPING: begin
                if (enable) state_d = RUN;
                else if (tick && f_wrap) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Divider, counters and markers.
    always_comb begin
        div_d   = div;
        col_d   = currentColumn;
        row_d   = currentRow;
        line_d  = 1'b0;
        frame_d = 1'b0;
        count_d = frame_count;
        if (state == IDLE) begin
            div_d = '0;
            col_d = '0;
            row_d = '0;
            if (state_d == RUN) begin
                frame_d = 1'b1;
                count_d = frame_count + 16'd1;
            end
        end else begin
            div_d = tick ? '0 : div + 1'b1;
            if (tick) begin
                col_d = h_wrap ? '0 : currentColumn + 10'd1;
                if (h_wrap) begin
                    line_d = 1'b1;
                    row_d  = (currentRow == V_LAST) ? '0 : currentRow + 10'd1;
                end
                if (f_wrap) begin
                    frame_d = 1'b1;
                    count_d = frame_count + 16'd1;
                end
            end
            if (state_d == IDLE) begin
                div_d   = '0;
                col_d   = '0;
                row_d   = '0;
                line_d  = 1'b0;
                frame_d = 1'b0;
                count_d = frame_count;
            end
        end
    end

    // Decode from next counter values so registered outputs track the counters.
    always_comb begin
        busy_d  = (state_d != IDLE);
        tick_d  = busy_d && (div_d == DIV_LAST);
        video_d = busy_d && (col_d < H_ACT) && (row_d < V_ACT);
        hsync_d = !(busy_d && (col_d >= HS_FIRST) && (col_d <= HS_LAST));
        vsync_d = !(busy_d && (row_d >= VS_FIRST) && (row_d <= VS_LAST));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div           <= '0;
            currentColumn <= '0;
            currentRow    <= '0;
            pixel_tick    <= 1'b0;
            video_on      <= 1'b0;
            hsync         <= 1'b1;
            vsync         <= 1'b1;
            line_start    <= 1'b0;
            frame_start   <= 1'b0;
            frame_count   <= '0;
            busy          <= 1'b0;
        end else begin
            div           <= div_d;
            currentColumn <= col_d;
            currentRow    <= row_d;
            pixel_tick    <= tick_d;
            video_on      <= video_d;
            hsync         <= hsync_d;
            vsync         <= vsync_d;
            line_start    <= line_d;
            frame_start   <= frame_d;
            frame_count   <= count_d;
            busy          <= busy_d;
        end
    end

endmodule

// File: tb/tb_vga_timing_controller.sv
// Directed bench for vga_timing_controller on a shrunken raster
// (16 x 10 pixels, CLK_DIV 4: 64 clks per line, 640 clks per frame).
module tb_vga_timing_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic        pixel_tick;
    logic [9:0]  currentColumn;
    logic [9:0]  currentRow;
    logic        video_on;
    logic        hsync;
    logic        vsync;
    logic        line_start;
    logic        frame_start;
    logic [15:0] frame_count;
    logic        busy;

    int total = 0;
    int bad = 0;

    vga_timing_controller #(
        .CLK_DIV (4),
        .H_ACTIVE(8),
        .H_FP    (2),
        .H_SYNC  (3),
        .H_BP    (3),
        .V_ACTIVE(6),
        .V_FP    (1),
        .V_SYNC  (2),
        .V_BP    (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .pixel_tick   (pixel_tick),
        .currentColumn(currentColumn),
        .currentRow   (currentRow),
        .video_on     (video_on),
        .hsync        (hsync),
        .vsync        (vsync),
        .line_start   (line_start),
        .frame_start  (frame_start),
        .frame_count  (frame_count),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic idle_outputs(input string tag, input logic [15:0] fc);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_col"}, currentColumn, 0);
        chk({tag, "_row"}, currentRow, 0);
        chk({tag, "_hs"}, hsync, 1);
        chk({tag, "_vs"}, vsync, 1);
        chk({tag, "_vid"}, video_on, 0);
        chk({tag, "_tick"}, pixel_tick, 0);
        chk({tag, "_ls"}, line_start, 0);
        chk({tag, "_fs"}, frame_start, 0);
        chk({tag, "_fc"}, frame_count, fc);
    endtask

    initial begin
        int n;
        int ls_at;
        int fs_at;
        int hl;
        int vl;
        int vo;
        int vbad;
        int vrow_bad;
        int hfirst;
        int vfirst;
        int fs_seen;
        int drops;
        int lastc;
        int lastr;

        // Reset state
        repeat (3) @(negedge clk);
        idle_outputs("rst", 0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_no_en_busy", busy, 0);
        enable = 1'b1;

        // Start: frame_start with first edge, first tick after 4 clks
        @(negedge clk);
        chk("start_busy", busy, 1);
        chk("start_fs", frame_start, 1);
        chk("start_fc", frame_count, 1);
        chk("start_col", currentColumn, 0);
        chk("start_vid", video_on, 1);
        @(negedge clk);
        chk("start_fs_pulse", frame_start, 0);
        @(negedge clk);
        @(negedge clk);
        chk("first_tick", pixel_tick, 1);
        chk("col_before_tick", currentColumn, 0);
        @(negedge clk);
        chk("col_after_tick", currentColumn, 1);
        chk("tick_one_clk", pixel_tick, 0);

        // One line
        n = 0;
        while (!line_start && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("wait_ls", n < 200, 1);
        ls_at = 0;
        hl = 0;
        vo = 0;
        hfirst = -1;
        for (int i = 1; i <= 64; i++) begin
            @(negedge clk);
            if (line_start && ls_at == 0) ls_at = i;
            if (!hsync) begin
                hl++;
                if (hfirst < 0) hfirst = int'(currentColumn);
            end
            if (video_on) vo++;
        end
        chk("line_period", ls_at, 64);
        chk("hsync_low_clks", hl, 12);
        chk("hsync_first_col", hfirst, 10);
        chk("video_clks_line", vo, 32);

        // Two frames
        n = 0;
        while (!frame_start && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("wait_fs", n < 1000, 1);
        chk("fc_2", frame_count, 2);
        fs_at = 0;
        vl = 0;
        vbad = 0;
        vrow_bad = 0;
        vfirst = -1;
        for (int i = 1; i <= 640; i++) begin
            @(negedge clk);
            if (frame_start && fs_at == 0) fs_at = i;
            if (!vsync) begin
                vl++;
                if (vfirst < 0) vfirst = int'(currentRow);
                if (currentRow < 7 || currentRow > 8) vrow_bad++;
            end
            if (video_on && currentRow >= 6) vbad++;
        end
        chk("frame_period", fs_at, 640);
        chk("vsync_low_clks", vl, 128);
        chk("vsync_first_row", vfirst, 7);
        chk("vsync_row_range", vrow_bad, 0);
        chk("video_blank_rows", vbad, 0);
        chk("fc_3", frame_count, 3);

        // Stop requested mid-frame
        n = 0;
        while (currentRow != 3 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("wait_row3", n < 1000, 1);
        enable = 1'b0;
        n = 0;
        fs_seen = 0;
        lastc = -1;
        lastr = -1;
        while (n < 1000) begin
            @(negedge clk);
            n++;
            if (!busy) break;
            if (frame_start) fs_seen++;
            lastc = int'(currentColumn);
            lastr = int'(currentRow);
        end
        chk("stop_reached", busy, 0);
        chk("stop_last_col", lastc, 15);
        chk("stop_last_row", lastr, 9);
        chk("stop_no_fs", fs_seen, 0);
        idle_outputs("stopped", 3);
        repeat (5) @(negedge clk);
        chk("stay_idle", busy, 0);
        enable = 1'b1;
        @(negedge clk);
        chk("restart_fs", frame_start, 1);
        chk("restart_fc", frame_count, 4);
        chk("restart_col", currentColumn, 0);
        chk("restart_row", currentRow, 0);

        // Brief enable drop inside a frame
        repeat (100) @(negedge clk);
        enable = 1'b0;
        repeat (50) @(negedge clk);
        enable = 1'b1;
        n = 150;
        drops = 0;
        while (n < 1000) begin
            @(negedge clk);
            n++;
            if (!busy) drops++;
            if (frame_start) break;
        end
        chk("toggle_period", n, 640);
        chk("toggle_no_stop", drops, 0);
        chk("toggle_fc", frame_count, 5);

        // enable falls on the same edge as the final wrap
        n = 0;
        while (!(currentColumn == 15 && currentRow == 9 && pixel_tick)
               && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("wait_last_px", n < 1000, 1);
        enable = 1'b0;
        @(negedge clk);
        chk("edge_wrap_fs", frame_start, 1);
        chk("edge_wrap_fc", frame_count, 6);
        chk("edge_wrap_busy", busy, 1);
        n = 0;
        while (busy && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("edge_full_frame", n, 640);
        chk("edge_fc_kept", frame_count, 6);

        // Asynchronous reset mid-frame
        enable = 1'b1;
        @(negedge clk);
        chk("pre_rst_fc", frame_count, 7);
        n = 0;
        while (!(currentColumn == 14 && currentRow == 4) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("wait_rst_pt", n < 1000, 1);
        #2;
        rst = 1'b0;
        #1;
        idle_outputs("async_rst", 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", busy, 1);
        chk("post_rst_fs", frame_start, 1);
        chk("post_rst_fc", frame_count, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
